delay_measure: RTL and testbench
================================

Name: delay_measure

Overview:
Measures in clock cycles the propagation delay between a transition on a stimulus signal and the matching transition on a response signal. It is the observing end of the delayed-assignment models: the models apply delays, and this block reads them back as numbers. Results leave through a valid/ready handshake to a logger or scoreboard. Glitch pulses shorter than the response delay are counted as rejected.

Parameters:
CNT_W, 16, width of the cycle counter and of meas_cycles
MAX_WAIT, 1000, timeout in cycles; must be ≤ 2^CNT_W-1 and ≥ 1
INVERT, 1, 1: resp matches when it settles to ~stim; 0: resp matches when it settles to stim
REJ_W, 8, width of the rejected-pulse counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  measurement enable
stim  in  1  stimulus signal, synchronous to clk
resp  in  1  response signal, synchronous to clk
meas_valid  out  1  result available
meas_ready  in  1  consumer accepts result
meas_cycles  out  CNT_W  measured delay in cycles
meas_timeout  out  1  result is a timeout; meas_cycles = MAX_WAIT
busy  out  1  state is COUNT
missed  out  1  sticky: stim edge arrived while in HOLD; cleared only by reset
rej_cnt  out  REJ_W  rejected (re-triggered) pulses; saturates at all-ones

Behaviour:
- Reset (async, rst_n=0):
  - outputs: meas_valid=0, meas_cycles=0, meas_timeout=0, busy=0, missed=0, rej_cnt=0.
  - internal: state=IDLE, stim_q=0, resp_q=0, prime=0.
- Edge detection:
  - stim_e = stim^stim_q; resp_e = resp^resp_q (stim_q/resp_q registered each cycle).
  - For the first cycle after reset release, prime=0: stim_e and resp_e are forced to 0 and prime is set to 1.
  - Match condition: resp_e && (resp == (INVERT ? ~stim : stim)).
- IDLE:
  - stim_e && en && match in the same cycle: go to HOLD with meas_cycles=0.
  - stim_e && en otherwise: go to COUNT with cnt=1.
- COUNT (busy=1), checked in this priority order each cycle:
  1. en=0: abort to IDLE; no result, rej_cnt unchanged.
  2. stim_e: rej_cnt+1 (saturating), cnt=1, stay in COUNT. The re-trigger restarts the measurement from the new edge.
  3. match: go to HOLD, meas_cycles=cnt, meas_timeout=0.
  4. cnt==MAX_WAIT: go to HOLD, meas_cycles=MAX_WAIT, meas_timeout=1.
  5. otherwise: cnt+1.
- HOLD (meas_valid=1):
  - meas_cycles and meas_timeout are held stable until meas_valid && meas_ready.
  - A stim_e while no handshake occurs sets missed=1; the edge is otherwise ignored.
  - Handshake cycle: next state is IDLE. If stim_e && en arrive in the same cycle, the edge starts a new measurement (COUNT, cnt=1) instead, and missed is not set.
- Latency:
  - meas_cycles = number of rising clk edges from the edge that registers the stim transition to the edge that registers the resp transition.
  - meas_valid rises on the clock edge that registers the match.
- Other states and modes:
  - en=0 in IDLE: edges are ignored; stim_q/resp_q still track their inputs.
  - meas_ready has no effect outside HOLD.
- Width rules:
  - cnt is CNT_W bits and cannot wrap, because the timeout fires at MAX_WAIT.
  - rej_cnt saturates at 2^REJ_W-1.

Decomposition:
- Shared package delay_pkg:
  - state enum (IDLE, COUNT, HOLD)
  - default CNT_W and MAX_WAIT constants
- One sub-module, delay_edge_det: holds the registered copy and the prime gating, and outputs the edge pulse. It is instantiated twice, once for stim and once for resp.

Test Plan:
- stim 0→1 at cycle 10; resp 1→0 at cycle 15; INVERT=1; meas_ready=1 → meas_valid one cycle, meas_cycles=5, meas_timeout=0.
- stim 1→0 at cycle 10; resp 0→1 at cycle 13; stim 0→1 at cycle 16; resp 1→0 at cycle 19; meas_ready=0 until cycle 25 →
  - first result 3 is held stable from cycle 13 to cycle 25;
  - the stim edge at cycle 16 sets missed=1;
  - the later resp edge is ignored and no second result is produced.
- stim toggles at cycles 10 and 13, resp never matches before 13; resp matches at cycle 18 → rej_cnt=1, meas_cycles=5.
- stim edge with resp held constant, MAX_WAIT=20 → meas_valid with meas_timeout=1 and meas_cycles=20.
- stim edge and matching resp edge in the same cycle → meas_cycles=0.
- rst_n pulsed low during COUNT (cnt=7) → all outputs 0 immediately; first cycle after release produces no edge even if stim≠0.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared definitions for the delay_measure block: FSM state encoding and
// default sizing constants.
package delay_pkg;

   localparam int unsigned DEF_CNT_W    = 16;
   localparam int unsigned DEF_MAX_WAIT = 1000;
   localparam int unsigned DEF_REJ_W    = 8;

   // IDLE: waiting for a stim edge; COUNT: timing the response;
   // HOLD: result presented on the valid/ready port.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_e;

endpackage : delay_pkg

// File: rtl/delay_edge_det.sv
// Single-bit transition detector.
//   clk, rst_n : clock and async active-low reset
//   sig        : monitored signal, synchronous to clk
//   sig_e_c    : combinational pulse, high when sig differs from last cycle
// The pulse is suppressed for the first cycle after reset release so that a
// non-zero level at release is not mistaken for a transition.
module delay_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic sig_e_c
);

   logic sig_q, sig_d;
   logic prime_q, prime_d;

   // Next-state: track the input every cycle, arm the detector once.
   always_comb begin
      sig_d   = sig;
      prime_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q   <= 1'b0;
         prime_q <= 1'b0;
      end else begin
         sig_q   <= sig_d;
         prime_q <= prime_d;
      end
   end

   assign sig_e_c = prime_q & (sig ^ sig_q);

endmodule : delay_edge_det

// File: rtl/delay_measure.sv
// Measures, in clock cycles, the delay from a stim transition to the matching
// resp transition and presents the result on a valid/ready port.
//   clk, rst_n   : clock and async active-low reset
//   en           : measurement enable
//   stim, resp   : stimulus and response signals, synchronous to clk
//   meas_valid   : result available (state HOLD)
//   meas_ready   : consumer accepts result
//   meas_cycles  : measured delay, or MAX_WAIT on timeout
//   meas_timeout : result is a timeout
//   busy         : measurement in progress (state COUNT)
//   missed       : sticky, a stim edge arrived while a result was pending
//   rej_cnt      : saturating count of re-triggered (rejected) pulses
module delay_measure
   import delay_pkg::*;
#(
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
   parameter bit          INVERT   = 1'b1,
   parameter int unsigned REJ_W    = DEF_REJ_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             stim,
   input  logic             resp,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [CNT_W-1:0] meas_cycles,
   output logic             meas_timeout,
   output logic             busy,
   output logic             missed,
   output logic [REJ_W-1:0] rej_cnt
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   logic stim_e;
   logic resp_e;
   logic match_c;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] meas_cycles_q, meas_cycles_d;
   logic             meas_timeout_q, meas_timeout_d;
   logic             meas_valid_q, meas_valid_d;
   logic             busy_q, busy_d;
   logic             missed_q, missed_d;
   logic [REJ_W-1:0] rej_cnt_q, rej_cnt_d;

   delay_edge_det u_stim_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig     (stim),
      .sig_e_c (stim_e)
   );

   delay_edge_det u_resp_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig     (resp),
      .sig_e_c (resp_e)
   );

   // Response has moved and settled to the level that answers the stimulus.
   assign match_c = resp_e && (resp == (INVERT ? ~stim : stim));

   // Next-state and next-output logic.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      meas_cycles_d  = meas_cycles_q;
      meas_timeout_d = meas_timeout_q;
      missed_d       = missed_q;
      rej_cnt_d      = rej_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (stim_e && en) begin
               if (match_c) begin
                  // Zero-delay response: result is ready immediately.
                  state_d        = HOLD;
                  meas_cycles_d  = '0;
                  meas_timeout_d = 1'b0;
               end else begin
                  state_d = COUNT;
                  cnt_d   = ONE_CNT;
               end
            end
         end

         COUNT: begin
            if (!en) begin
               state_d = IDLE;
            end else if (stim_e) begin
               // Stimulus moved again before the response: reject the
               // earlier pulse and time from the newest edge.
               if (rej_cnt_q != '1) begin
                  rej_cnt_d = rej_cnt_q + REJ_W'(1);
               end
               cnt_d = ONE_CNT;
            end else if (match_c) begin
               state_d        = HOLD;
               meas_cycles_d  = cnt_q;
               meas_timeout_d = 1'b0;
            end else if (cnt_q == MAX_CNT) begin
               state_d        = HOLD;
               meas_cycles_d  = MAX_CNT;
               meas_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE_CNT;
            end
         end

         HOLD: begin
            if (meas_ready) begin
               // An edge coinciding with the handshake starts a new run.
               if (stim_e && en) begin
                  state_d = COUNT;
                  cnt_d   = ONE_CNT;
               end else begin
                  state_d = IDLE;
               end
            end else if (stim_e) begin
               missed_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      meas_valid_d = (state_d == HOLD);
      busy_d       = (state_d == COUNT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         meas_cycles_q  <= '0;
         meas_timeout_q <= 1'b0;
         meas_valid_q   <= 1'b0;
         busy_q         <= 1'b0;
         missed_q       <= 1'b0;
         rej_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         meas_cycles_q  <= meas_cycles_d;
         meas_timeout_q <= meas_timeout_d;
         meas_valid_q   <= meas_valid_d;
         busy_q         <= busy_d;
         missed_q       <= missed_d;
         rej_cnt_q      <= rej_cnt_d;
      end
   end

   assign meas_valid   = meas_valid_q;
   assign meas_cycles  = meas_cycles_q;
   assign meas_timeout = meas_timeout_q;
   assign busy         = busy_q;
   assign missed       = missed_q;
   assign rej_cnt      = rej_cnt_q;

endmodule : delay_measure

// File: tb/tb_delay_measure.sv
// Testbench for delay_measure: directed scenarios followed by random traffic,
// all compared each cycle against a timestamp-based reference model.
module tb_delay_measure;

   localparam int unsigned CW  = 16;
   localparam int unsigned MW  = 20;
   localparam int unsigned RW  = 3;
   localparam int          REJ_MAX = (1 << RW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          stim;
   logic          resp;
   logic          meas_valid;
   logic          meas_ready;
   logic [CW-1:0] meas_cycles;
   logic          meas_timeout;
   logic          busy;
   logic          missed;
   logic [RW-1:0] rej_cnt;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state: measurement phase plus start timestamp.
   int now;
   bit m_primed;
   bit m_pst, m_prs;
   bit m_counting, m_holding;
   int m_start;
   int e_cycles, e_rej;
   bit e_timeout, e_missed;

   delay_measure #(
      .CNT_W    (CW),
      .MAX_WAIT (MW),
      .INVERT   (1'b1),
      .REJ_W    (RW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .stim         (stim),
      .resp         (resp),
      .meas_valid   (meas_valid),
      .meas_ready   (meas_ready),
      .meas_cycles  (meas_cycles),
      .meas_timeout (meas_timeout),
      .busy         (busy),
      .missed       (missed),
      .rej_cnt      (rej_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_chk++;
      assert (obs === 32'(exp)) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_primed   = 1'b0;
      m_pst      = 1'b0;
      m_prs      = 1'b0;
      m_counting = 1'b0;
      m_holding  = 1'b0;
      m_start    = 0;
      e_cycles   = 0;
      e_rej      = 0;
      e_timeout  = 1'b0;
      e_missed   = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs about to be sampled.
   task automatic model_step();
      bit se, re, match;
      now++;
      se    = m_primed && (stim != m_pst);
      re    = m_primed && (resp != m_prs);
      match = re && (resp == !stim);
      m_primed = 1'b1;
      m_pst    = stim;
      m_prs    = resp;
      if (m_holding) begin
         if (meas_ready) begin
            m_holding = 1'b0;
            if (se && en) begin
               m_counting = 1'b1;
               m_start    = now;
            end
         end else if (se) begin
            e_missed = 1'b1;
         end
      end else if (m_counting) begin
         if (!en) begin
            m_counting = 1'b0;
         end else if (se) begin
            e_rej   = (e_rej < REJ_MAX) ? e_rej + 1 : REJ_MAX;
            m_start = now;
         end else if (match) begin
            m_counting = 1'b0;
            m_holding  = 1'b1;
            e_cycles   = now - m_start;
            e_timeout  = 1'b0;
         end else if (now - m_start == MW) begin
            m_counting = 1'b0;
            m_holding  = 1'b1;
            e_cycles   = MW;
            e_timeout  = 1'b1;
         end
      end else if (se && en) begin
         if (match) begin
            m_holding = 1'b1;
            e_cycles  = 0;
            e_timeout = 1'b0;
         end else begin
            m_counting = 1'b1;
            m_start    = now;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"},   32'(meas_valid),   int'(m_holding));
      chk({tag, ".cycles"},  32'(meas_cycles),  e_cycles);
      chk({tag, ".timeout"}, 32'(meas_timeout), int'(e_timeout));
      chk({tag, ".busy"},    32'(busy),         int'(m_counting));
      chk({tag, ".missed"},  32'(missed),       int'(e_missed));
      chk({tag, ".rej"},     32'(rej_cnt),      e_rej);
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic ticks(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   // Asynchronous reset pulse between clock edges.
   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("rst");
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      now        = 0;
      rst_n      = 1'b0;
      en         = 1'b0;
      stim       = 1'b0;
      resp       = 1'b0;
      meas_ready = 1'b0;
      model_reset();
      #1;
      check_all("por");
      chk("por_valid", 32'(meas_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic 5-cycle measurement with immediate acceptance.
      en = 1'b1; meas_ready = 1'b1; resp = 1'b1;
      ticks(10, "t1_idle");
      stim = 1'b1; tick("t1_stim");
      ticks(4, "t1_cnt");
      resp = 1'b0; tick("t1_match");
      chk("t1_valid", 32'(meas_valid), 1);
      chk("t1_cycles", 32'(meas_cycles), 5);
      chk("t1_tmo", 32'(meas_timeout), 0);
      tick("t1_ack");
      chk("t1_valid_drop", 32'(meas_valid), 0);

      // Result held under back-pressure; edge during HOLD flagged as missed.
      meas_ready = 1'b0;
      stim = 1'b0; tick("t2_stim");
      ticks(2, "t2_cnt");
      resp = 1'b1; tick("t2_match");
      chk("t2_cycles", 32'(meas_cycles), 3);
      ticks(2, "t2_hold");
      stim = 1'b1; tick("t2_miss");
      chk("t2_missed", 32'(missed), 1);
      ticks(2, "t2_hold");
      resp = 1'b0; tick("t2_resp_ign");
      ticks(5, "t2_hold");
      chk("t2_held_valid", 32'(meas_valid), 1);
      chk("t2_held_cycles", 32'(meas_cycles), 3);
      meas_ready = 1'b1; tick("t2_ack");
      ticks(3, "t2_after");
      chk("t2_no_second", 32'(meas_valid), 0);
      chk("t2_idle", 32'(busy), 0);

      // Re-trigger: second stim edge restarts timing and counts a rejection.
      resp = 1'b1; ticks(2, "t3_pre");
      stim = 1'b0; tick("t3_s1");
      ticks(2, "t3_cnt");
      stim = 1'b1; tick("t3_s2");
      ticks(4, "t3_cnt");
      resp = 1'b0; tick("t3_match");
      chk("t3_rej", 32'(rej_cnt), 1);
      chk("t3_cycles", 32'(meas_cycles), 5);
      tick("t3_ack");

      // Timeout with a silent response.
      meas_ready = 1'b0;
      stim = 1'b0; tick("t4_stim");
      ticks(MW - 1, "t4_cnt");
      chk("t4_pre_busy", 32'(busy), 1);
      tick("t4_tmo");
      chk("t4_valid", 32'(meas_valid), 1);
      chk("t4_tmo", 32'(meas_timeout), 1);
      chk("t4_cycles", 32'(meas_cycles), MW);
      meas_ready = 1'b1; tick("t4_ack");

      // Stimulus and matching response in the same cycle.
      resp = 1'b1; tick("t5_pre");
      stim = 1'b1; resp = 1'b0; tick("t5_same");
      chk("t5_valid", 32'(meas_valid), 1);
      chk("t5_cycles", 32'(meas_cycles), 0);
      chk("t5_tmo", 32'(meas_timeout), 0);
      tick("t5_ack");

      // Rejected-pulse counter saturation.
      for (int i = 0; i < 10; i++) begin
         stim = ~stim; tick("t7_toggle");
      end
      chk("t7_rej_sat", 32'(rej_cnt), REJ_MAX);
      en = 1'b0; tick("t7_abort");
      chk("t7_abort_busy", 32'(busy), 0);
      en = 1'b1;

      // Reset in the middle of a measurement; no false edge after release.
      stim = 1'b0; tick("t6_pre");
      stim = 1'b1; tick("t6_stim");
      ticks(6, "t6_cnt");
      chk("t6_busy", 32'(busy), 1);
      stim = 1'b0;
      do_reset();
      chk("t6_rej0", 32'(rej_cnt), 0);
      chk("t6_busy0", 32'(busy), 0);
      stim = 1'b1; resp = 1'b1;
      tick("t6_first");
      chk("t6_no_edge", 32'(busy), 0);
      ticks(3, "t6_quiet");

      // Random traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         en         = ($urandom_range(0, 19) != 0);
         meas_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 5) == 0) stim = ~stim;
         if ($urandom_range(0, 7) == 0) resp = ~resp;
         if ($urandom_range(0, 499) == 0) do_reset();
         tick("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_delay_measure
